axis_trace_serializer: RTL and testbench
========================================

Name: axis_trace_serializer

Overview:
- Sits directly downstream of the monitoring block's AXI-Stream master, between it and the DMA/FIFO.
- Accepts one wide trace packet per transfer (IN_WIDTH bits, of which only the low ACTIVE_BEATS*OUT_WIDTH bits carry data: pc, clk delta, instr, perf counter).
- Re-emits each packet as ACTIVE_BEATS narrow AXI-Stream beats, so the DMA does not move mostly-zero 1024-bit words.
- Preserves tlast on the final beat and counts forwarded packets.

Parameters:
- IN_WIDTH, 1024, slave tdata width; must be a multiple of OUT_WIDTH.
- OUT_WIDTH, 64, master tdata width.
- ACTIVE_BEATS, 3, beats emitted per packet; legal range 1..IN_WIDTH/OUT_WIDTH; beat k carries bits [k*OUT_WIDTH +: OUT_WIDTH].
- COUNT_WIDTH, 32, width of pkt_count.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- S_AXIS_tvalid  in  1  packet valid from monitor
- S_AXIS_tready  out  1  serializer can accept packet
- S_AXIS_tdata  in  IN_WIDTH  packet
- S_AXIS_tlast  in  1  packet ends a DMA transfer
- M_AXIS_tvalid  out  1  beat valid
- M_AXIS_tready  in  1  downstream accepts beat
- M_AXIS_tdata  out  OUT_WIDTH  beat data
- M_AXIS_tlast  out  1  final beat of a tlast packet
- busy  out  1  packet held, beats outstanding
- pkt_count  out  COUNT_WIDTH  packets fully forwarded since reset

Behaviour:
- State is a holding register (hold_data, hold_last), beat index beat_idx (clog2(ACTIVE_BEATS) bits, min 1), and full flag. FSM: EMPTY (full=0), SEND (full=1).
- Reset values (cycle after rst_n low sampled): full=0, beat_idx=0, hold_data=0, hold_last=0, pkt_count=0. M_AXIS_tvalid=0, M_AXIS_tlast=0, busy=0. S_AXIS_tready=0 while rst_n=0, 1 after.
- S_AXIS_tready = rst_n & (~full | final_handshake), where final_handshake = full & M_AXIS_tready & beat_idx==ACTIVE_BEATS-1. Combinational path M_AXIS_tready -> S_AXIS_tready is accepted.
- EMPTY: an S handshake captures tdata/tlast, sets full, beat_idx=0, moves to SEND. Latency is 1 cycle from slave handshake to first M_AXIS_tvalid.
- SEND:
  - M_AXIS_tvalid=1.
  - M_AXIS_tdata = hold_data[beat_idx*OUT_WIDTH +: OUT_WIDTH].
  - M_AXIS_tlast = hold_last & beat_idx==ACTIVE_BEATS-1.
  - An M handshake on a non-final beat increments beat_idx.
  - A final handshake increments pkt_count (wraps modulo 2^COUNT_WIDTH). Then, if an S handshake occurs in the same cycle, it loads the new packet with beat_idx=0 and stays in SEND (zero-bubble back-to-back). Otherwise it clears full and goes to EMPTY.
- AXI rules: while M_AXIS_tvalid=1 and M_AXIS_tready=0, tdata/tlast are held stable. tvalid never drops without a handshake except on reset.
- Upper bits of S_AXIS_tdata beyond ACTIVE_BEATS*OUT_WIDTH are ignored and need not be stored.
- ACTIVE_BEATS=1: every M handshake is final; acts as a 1-deep register slice with pass-through throughput.
- Throughput: sustained 1 beat/cycle with M_AXIS_tready=1; slave accepts at most 1 packet per ACTIVE_BEATS cycles.
- Reset mid-packet: remaining beats are discarded and pkt_count cleared. M_AXIS_tvalid is 0 in the cycle after rst_n is sampled low; no partial tlast is emitted.
- busy = full.

Decomposition:
- Shared package trace_pkg holds packet field constants: PC_LSB=0/width 64, DELTA_LSB=64/width 64, INSTR_LSB=128/width 32, PERF_LSB=160/width 7, TRACE_ACTIVE_BITS=167, and the default OUT_WIDTH/ACTIVE_BEATS. The monitor and the host-side decoder use the same values.
- No sub-module: beat mux and FSM stay in one module.

Test Plan:
- Packet tdata low 192 bits = {64'hC, 64'hB, 64'hA}, tlast=0, tready=1 -> beats A,B,C on 3 consecutive cycles starting 1 cycle after handshake; tlast=0 on all; pkt_count=1.
- Same packet with tlast=1, tready toggling 1,0,0,1,1 -> beats A,A,A,B,C; data stable during stalls; M_AXIS_tlast=1 only with C; S_AXIS_tready=0 until C accepted.
- Two packets P1={3,2,1}, P2={6,5,4} offered back-to-back, tready=1 -> beats 1,2,3,4,5,6 with no idle cycle; P2 accepted in the same cycle as beat 3; pkt_count=2.
- rst_n low for 1 cycle after beat A of a 3-beat packet -> M_AXIS_tvalid=0, pkt_count=0 next cycle. A fresh packet {9,8,7} then yields 7,8,9 only.
- ACTIVE_BEATS=1, 4 packets (0x11..0x44), tready=1 -> 4 beats on 4 consecutive cycles.
- COUNT_WIDTH=4, 17 packets -> pkt_count wraps to 0 at 16 and reads 1 after the 17th.

Source files
------------

// File: rtl/trace_pkg.sv
// Trace packet field layout shared by the monitor, this serializer and the host decoder.
// Also carries the serializer FSM state type and default beat geometry.
package trace_pkg;

    localparam int PC_LSB             = 0;
    localparam int PC_WIDTH           = 64;
    localparam int DELTA_LSB          = 64;
    localparam int DELTA_WIDTH        = 64;
    localparam int INSTR_LSB          = 128;
    localparam int INSTR_WIDTH        = 32;
    localparam int PERF_LSB           = 160;
    localparam int PERF_WIDTH         = 7;
    localparam int TRACE_ACTIVE_BITS  = 167;

    localparam int TRACE_OUT_WIDTH    = 64;
    localparam int TRACE_ACTIVE_BEATS = 3;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_SEND  = 1'b1
    } ser_state_e;

endpackage

// File: rtl/axis_trace_serializer.sv
// Splits one wide AXI-Stream trace packet into ACTIVE_BEATS narrow beats, keeping
// tlast on the final beat and counting fully forwarded packets.
//
// state    | meaning
// ST_EMPTY | no packet held, slave side ready
// ST_SEND  | packet held, beat beat_idx_q presented on the master side
module axis_trace_serializer
    import trace_pkg::*;
#(
    parameter int IN_WIDTH     = 1024,
    parameter int OUT_WIDTH    = TRACE_OUT_WIDTH,
    parameter int ACTIVE_BEATS = TRACE_ACTIVE_BEATS,
    parameter int COUNT_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   S_AXIS_tvalid,
    output logic                   S_AXIS_tready,
    input  logic [IN_WIDTH-1:0]    S_AXIS_tdata,
    input  logic                   S_AXIS_tlast,
    output logic                   M_AXIS_tvalid,
    input  logic                   M_AXIS_tready,
    output logic [OUT_WIDTH-1:0]   M_AXIS_tdata,
    output logic                   M_AXIS_tlast,
    output logic                   busy,
    output logic [COUNT_WIDTH-1:0] pkt_count
);

    localparam int HOLD_W = ACTIVE_BEATS * OUT_WIDTH;
    localparam int IDX_W  = (ACTIVE_BEATS > 1) ? $clog2(ACTIVE_BEATS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ACTIVE_BEATS - 1);

    ser_state_e             state_q, state_d;
    logic [HOLD_W-1:0]      hold_data_q, hold_data_d;
    logic                   hold_last_q, hold_last_d;
    logic [IDX_W-1:0]       beat_idx_q, beat_idx_d;
    logic [COUNT_WIDTH-1:0] pkt_count_q, pkt_count_d;

    logic full;
    logic final_hs;
    logic s_hs;
    logic m_hs;
    logic [OUT_WIDTH-1:0] beat_data;

    // Only the active low bits of the packet are held; the rest is dropped here.
    if (IN_WIDTH > HOLD_W) begin : g_unused_hi
        logic unused_tdata_hi;
        assign unused_tdata_hi = ^S_AXIS_tdata[IN_WIDTH-1:HOLD_W];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            hold_data_q <= '0;
            hold_last_q <= 1'b0;
            beat_idx_q  <= '0;
            pkt_count_q <= '0;
        end else begin
            state_q     <= state_d;
            hold_data_q <= hold_data_d;
            hold_last_q <= hold_last_d;
            beat_idx_q  <= beat_idx_d;
            pkt_count_q <= pkt_count_d;
        end
    end

    always_comb begin
        beat_data = '0;
        for (int k = 0; k < ACTIVE_BEATS; k++) begin
            if (beat_idx_q == IDX_W'(k)) beat_data = hold_data_q[k*OUT_WIDTH +: OUT_WIDTH];
        end
    end

    // Freeing the holder on the final beat lets the next packet load with no bubble.
    assign full          = (state_q == ST_SEND);
    assign m_hs          = full & M_AXIS_tready;
    assign final_hs      = m_hs & (beat_idx_q == LAST_IDX);
    assign S_AXIS_tready = rst_n & (~full | final_hs);
    assign s_hs          = S_AXIS_tvalid & S_AXIS_tready;

    always_comb begin
        state_d     = state_q;
        hold_data_d = hold_data_q;
        hold_last_d = hold_last_q;
        beat_idx_d  = beat_idx_q;
        pkt_count_d = pkt_count_q;

        if (m_hs && !final_hs) beat_idx_d = beat_idx_q + IDX_W'(1);

        if (final_hs) begin
            pkt_count_d = pkt_count_q + COUNT_WIDTH'(1);
            beat_idx_d  = '0;
            state_d     = ST_EMPTY;
        end

        if (s_hs) begin
            hold_data_d = S_AXIS_tdata[HOLD_W-1:0];
            hold_last_d = S_AXIS_tlast;
            beat_idx_d  = '0;
            state_d     = ST_SEND;
        end
    end

    assign M_AXIS_tvalid = full;
    assign M_AXIS_tdata  = beat_data;
    assign M_AXIS_tlast  = full & hold_last_q & (beat_idx_q == LAST_IDX);
    assign busy          = full;
    assign pkt_count     = pkt_count_q;

endmodule

// File: tb/tb_axis_trace_serializer.sv
// Directed bench for axis_trace_serializer: default geometry, single-beat slice,
// and a narrow packet counter for wrap-around.
module tb_axis_trace_serializer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    // DUT0: default parameters
    logic          s0_tvalid = 1'b0, s0_tlast = 1'b0, m0_tready = 1'b0;
    logic [1023:0] s0_tdata = '0;
    logic          s0_tready, m0_tvalid, m0_tlast, busy0;
    logic [63:0]   m0_tdata;
    logic [31:0]   cnt0;

    // DUT1: ACTIVE_BEATS = 1
    logic          s1_tvalid = 1'b0, s1_tlast = 1'b0, m1_tready = 1'b0;
    logic [1023:0] s1_tdata = '0;
    logic          s1_tready, m1_tvalid, m1_tlast, busy1;
    logic [63:0]   m1_tdata;
    logic [31:0]   cnt1;

    // DUT2: COUNT_WIDTH = 4
    logic          s2_tvalid = 1'b0, s2_tlast = 1'b0, m2_tready = 1'b0;
    logic [1023:0] s2_tdata = '0;
    logic          s2_tready, m2_tvalid, m2_tlast, busy2;
    logic [63:0]   m2_tdata;
    logic [3:0]    cnt2;

    axis_trace_serializer u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .S_AXIS_tvalid(s0_tvalid), .S_AXIS_tready(s0_tready), .S_AXIS_tdata(s0_tdata), .S_AXIS_tlast(s0_tlast),
        .M_AXIS_tvalid(m0_tvalid), .M_AXIS_tready(m0_tready), .M_AXIS_tdata(m0_tdata), .M_AXIS_tlast(m0_tlast),
        .busy(busy0), .pkt_count(cnt0)
    );

    axis_trace_serializer #(.ACTIVE_BEATS(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .S_AXIS_tvalid(s1_tvalid), .S_AXIS_tready(s1_tready), .S_AXIS_tdata(s1_tdata), .S_AXIS_tlast(s1_tlast),
        .M_AXIS_tvalid(m1_tvalid), .M_AXIS_tready(m1_tready), .M_AXIS_tdata(m1_tdata), .M_AXIS_tlast(m1_tlast),
        .busy(busy1), .pkt_count(cnt1)
    );

    axis_trace_serializer #(.COUNT_WIDTH(4)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .S_AXIS_tvalid(s2_tvalid), .S_AXIS_tready(s2_tready), .S_AXIS_tdata(s2_tdata), .S_AXIS_tlast(s2_tlast),
        .M_AXIS_tvalid(m2_tvalid), .M_AXIS_tready(m2_tready), .M_AXIS_tdata(m2_tdata), .M_AXIS_tlast(m2_tlast),
        .busy(busy2), .pkt_count(cnt2)
    );

    // Packet with low three 64-bit words a, b, c and junk in the ignored upper bits.
    function automatic logic [1023:0] pkt3(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
        logic [1023:0] p;
        p = {1024{1'b1}};
        p[63:0]    = a;
        p[127:64]  = b;
        p[191:128] = c;
        return p;
    endfunction

    // Inputs change at the falling edge; outputs are sampled 1 ns later, well clear of the rising edge.
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cyc(); cyc();
        #1;
        n_total++;
        if (m0_tvalid !== 1'b0 || busy0 !== 1'b0 || m0_tlast !== 1'b0) $display("FAIL reset_outputs: tvalid=%b busy=%b tlast=%b required 0 0 0", m0_tvalid, busy0, m0_tlast);
        else n_pass++;
        n_total++;
        if (s0_tready !== 1'b0) $display("FAIL reset_s_tready_low: got %b required 0", s0_tready);
        else n_pass++;
        n_total++;
        if (cnt0 !== 32'd0) $display("FAIL reset_pkt_count: got %0d required 0", cnt0);
        else n_pass++;
        cyc();
        rst_n = 1'b1;
        #1;
        n_total++;
        if (s0_tready !== 1'b1 || s1_tready !== 1'b1 || s2_tready !== 1'b1) $display("FAIL reset_s_tready_high: got %b%b%b required 111", s0_tready, s1_tready, s2_tready);
        else n_pass++;
    endtask

    task automatic test_basic();
        logic [63:0] exp_beats [3];
        exp_beats[0] = 64'hA; exp_beats[1] = 64'hB; exp_beats[2] = 64'hC;
        cyc();
        s0_tvalid = 1'b1; s0_tdata = pkt3(64'hA, 64'hB, 64'hC); s0_tlast = 1'b0; m0_tready = 1'b1;
        #1;
        n_total++;
        if (s0_tready !== 1'b1 || m0_tvalid !== 1'b0) $display("FAIL basic_accept: s_tready=%b m_tvalid=%b required 1 0", s0_tready, m0_tvalid);
        else n_pass++;
        for (int k = 0; k < 3; k++) begin
            cyc();
            s0_tvalid = 1'b0;
            #1;
            n_total++;
            if (m0_tvalid !== 1'b1 || m0_tdata !== exp_beats[k] || m0_tlast !== 1'b0 || busy0 !== 1'b1)
                $display("FAIL basic_beat%0d: v=%b d=%h l=%b busy=%b required 1 %h 0 1", k, m0_tvalid, m0_tdata, m0_tlast, busy0, exp_beats[k]);
            else n_pass++;
        end
        cyc();
        #1;
        n_total++;
        if (m0_tvalid !== 1'b0 || busy0 !== 1'b0 || cnt0 !== 32'd1) $display("FAIL basic_done: v=%b busy=%b count=%0d required 0 0 1", m0_tvalid, busy0, cnt0);
        else n_pass++;
    endtask

    task automatic test_stall();
        logic        rdy [5];
        logic [63:0] ed [5];
        logic        el [5];
        logic        es [5];
        rdy = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        ed  = '{64'hA, 64'hA, 64'hA, 64'hB, 64'hC};
        el  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        es  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        cyc();
        s0_tvalid = 1'b1; s0_tdata = pkt3(64'hA, 64'hB, 64'hC); s0_tlast = 1'b1; m0_tready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cyc();
            s0_tvalid = 1'b0;
            m0_tready = rdy[k];
            #1;
            n_total++;
            if (m0_tvalid !== 1'b1 || m0_tdata !== ed[k] || m0_tlast !== el[k] || s0_tready !== es[k])
                $display("FAIL stall_cycle%0d: v=%b d=%h l=%b s_rdy=%b required 1 %h %b %b", k, m0_tvalid, m0_tdata, m0_tlast, s0_tready, ed[k], el[k], es[k]);
            else n_pass++;
        end
        cyc();
        #1;
        n_total++;
        if (m0_tvalid !== 1'b0 || cnt0 !== 32'd2) $display("FAIL stall_done: v=%b count=%0d required 0 2", m0_tvalid, cnt0);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [63:0] ed [6];
        logic        es [6];
        ed = '{64'd1, 64'd2, 64'd3, 64'd4, 64'd5, 64'd6};
        es = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        cyc();
        s0_tvalid = 1'b1; s0_tdata = pkt3(64'd1, 64'd2, 64'd3); s0_tlast = 1'b0; m0_tready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cyc();
            if (k == 0) s0_tdata = pkt3(64'd4, 64'd5, 64'd6);
            if (k == 3) s0_tvalid = 1'b0;
            #1;
            n_total++;
            if (m0_tvalid !== 1'b1 || m0_tdata !== ed[k] || m0_tlast !== 1'b0)
                $display("FAIL b2b_beat%0d: v=%b d=%h l=%b required 1 %h 0", k, m0_tvalid, m0_tdata, m0_tlast, ed[k]);
            else n_pass++;
            // s_tready only matters while P2 is still on offer
            if (k < 3) begin
                n_total++;
                if (s0_tready !== es[k]) $display("FAIL b2b_s_tready%0d: got %b required %b", k, s0_tready, es[k]);
                else n_pass++;
            end
        end
        cyc();
        #1;
        n_total++;
        if (m0_tvalid !== 1'b0 || cnt0 !== 32'd4) $display("FAIL b2b_done: v=%b count=%0d required 0 4", m0_tvalid, cnt0);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [63:0] ed [3];
        ed = '{64'd7, 64'd8, 64'd9};
        cyc();
        s0_tvalid = 1'b1; s0_tdata = pkt3(64'hA, 64'hB, 64'hC); s0_tlast = 1'b1; m0_tready = 1'b1;
        cyc();
        s0_tvalid = 1'b0;
        #1;
        n_total++;
        if (m0_tvalid !== 1'b1 || m0_tdata !== 64'hA) $display("FAIL rstmid_beatA: v=%b d=%h required 1 a", m0_tvalid, m0_tdata);
        else n_pass++;
        cyc();
        rst_n = 1'b0;
        #1;
        n_total++;
        if (s0_tready !== 1'b0) $display("FAIL rstmid_s_tready: got %b required 0", s0_tready);
        else n_pass++;
        cyc();
        rst_n = 1'b1;
        #1;
        n_total++;
        if (m0_tvalid !== 1'b0 || m0_tlast !== 1'b0 || busy0 !== 1'b0 || cnt0 !== 32'd0)
            $display("FAIL rstmid_cleared: v=%b l=%b busy=%b count=%0d required 0 0 0 0", m0_tvalid, m0_tlast, busy0, cnt0);
        else n_pass++;
        s0_tvalid = 1'b1; s0_tdata = pkt3(64'd7, 64'd8, 64'd9); s0_tlast = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            s0_tvalid = 1'b0;
            #1;
            n_total++;
            if (m0_tvalid !== 1'b1 || m0_tdata !== ed[k] || m0_tlast !== 1'b0)
                $display("FAIL rstmid_beat%0d: v=%b d=%h l=%b required 1 %h 0", k, m0_tvalid, m0_tdata, m0_tlast, ed[k]);
            else n_pass++;
        end
        cyc();
        #1;
        n_total++;
        if (m0_tvalid !== 1'b0 || cnt0 !== 32'd1) $display("FAIL rstmid_done: v=%b count=%0d required 0 1", m0_tvalid, cnt0);
        else n_pass++;
    endtask

    task automatic test_single_beat();
        logic [63:0] ed [4];
        logic [1023:0] p;
        ed = '{64'h11, 64'h22, 64'h33, 64'h44};
        cyc();
        m1_tready = 1'b1;
        s1_tvalid = 1'b1;
        p = {1024{1'b1}}; p[63:0] = ed[0]; s1_tdata = p; s1_tlast = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cyc();
            if (k < 3) begin
                p[63:0] = ed[k+1]; s1_tdata = p; s1_tlast = (k == 2);
            end else begin
                s1_tvalid = 1'b0; s1_tlast = 1'b0;
            end
            #1;
            n_total++;
            if (m1_tvalid !== 1'b1 || m1_tdata !== ed[k] || m1_tlast !== (k == 3) || s1_tready !== 1'b1)
                $display("FAIL ab1_beat%0d: v=%b d=%h l=%b s_rdy=%b required 1 %h %b 1", k, m1_tvalid, m1_tdata, m1_tlast, s1_tready, ed[k], (k == 3));
            else n_pass++;
        end
        cyc();
        #1;
        n_total++;
        if (m1_tvalid !== 1'b0 || cnt1 !== 32'd4) $display("FAIL ab1_done: v=%b count=%0d required 0 4", m1_tvalid, cnt1);
        else n_pass++;
    endtask

    task automatic test_count_wrap();
        m2_tready = 1'b1;
        s2_tlast  = 1'b0;
        for (int p = 0; p < 17; p++) begin
            cyc();
            // previous packet fully drained: count equals packets sent so far, mod 16
            #1;
            if (p == 15 || p == 16) begin
                n_total++;
                if (cnt2 !== 4'(p)) $display("FAIL wrap_count_after%0d: got %0d required %0d", p, cnt2, 4'(p));
                else n_pass++;
            end
            s2_tvalid = 1'b1;
            s2_tdata  = pkt3(64'(p), 64'(p + 100), 64'(p + 200));
            for (int k = 0; k < 3; k++) begin
                cyc();
                s2_tvalid = 1'b0;
            end
            #1;
            if (p == 16) begin
                n_total++;
                if (m2_tdata !== 64'd216 || m2_tvalid !== 1'b1) $display("FAIL wrap_last_beat: v=%b d=%h required 1 %h", m2_tvalid, m2_tdata, 64'd216);
                else n_pass++;
            end
        end
        cyc();
        #1;
        n_total++;
        if (cnt2 !== 4'd1 || m2_tvalid !== 1'b0) $display("FAIL wrap_count_final: count=%0d v=%b required 1 0", cnt2, m2_tvalid);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_single_beat();
        test_count_wrap();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
